// File: rtl/branch_cond_unit.sv
// Conditional-branch evaluator: waits out pending flag writes, evaluates the
// condition code against C/Z/V/S and returns taken/target over valid/ready.
module branch_cond_unit #(
    parameter int PC_W     = 16,
    parameter int OFF_W    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_c,
    input  logic             flag_z,
    input  logic             flag_v,
    input  logic             flag_s,
    input  logic             flag_pend,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cond,
    input  logic [PC_W-1:0]  req_pc,
    input  logic [OFF_W-1:0] req_off,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic [PC_W-1:0]  resp_target,
    output logic             resp_forced
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_EVAL, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cond_q, cond_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              force_q, force_d;
    logic              taken_q, taken_d;
    logic [PC_W-1:0]   target_q, target_d;
    logic              forced_q, forced_d;

    logic              cond_true;
    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   pc_inc;

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_q)
            4'd0:  cond_true = 1'b1;
            4'd1:  cond_true = flag_z;
            4'd2:  cond_true = !flag_z;
            4'd3:  cond_true = flag_c;
            4'd4:  cond_true = !flag_c;
            4'd5:  cond_true = flag_s;
            4'd6:  cond_true = !flag_s;
            4'd7:  cond_true = flag_v;
            4'd8:  cond_true = !flag_v;
            4'd9:  cond_true = flag_c && !flag_z;
            4'd10: cond_true = !flag_c || flag_z;
            4'd11: cond_true = (flag_s == flag_v);
            4'd12: cond_true = (flag_s != flag_v);
            4'd13: cond_true = !flag_z && (flag_s == flag_v);
            4'd14: cond_true = flag_z || (flag_s != flag_v);
            4'd15: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    // Sizing cast of a signed operand sign-extends; also valid when OFF_W == PC_W.
    assign off_ext = PC_W'($signed(off_q));
    assign pc_inc  = pc_q + PC_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cond_d   = cond_q;
        pc_d     = pc_q;
        off_d    = off_q;
        force_d  = force_q;
        taken_d  = taken_q;
        target_d = target_q;
        forced_d = forced_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cond_d  = req_cond;
                    pc_d    = req_pc;
                    off_d   = req_off;
                    force_d = 1'b0;
                    if (flag_pend) begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_HOLD: begin
                if (!flag_pend) begin
                    state_d = S_EVAL;
                end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
                    force_d = 1'b1;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                taken_d  = cond_true;
                target_d = cond_true ? (pc_inc + off_ext) : pc_inc;
                forced_d = force_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cond_q   <= '0;
            pc_q     <= '0;
            off_q    <= '0;
            force_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cond_q   <= cond_d;
            pc_q     <= pc_d;
            off_q    <= off_d;
            force_q  <= force_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            forced_q <= forced_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign resp_taken  = taken_q;
    assign resp_target = target_q;
    assign resp_forced = forced_q;

endmodule
